// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Handshake bundle between imem response, the prefetch buffer and the IF/ID register.
// Latency: none (wires only).
// Backpressure: in_ready toward imem and out_ready from IF/ID.
interface fetch_buffer_if
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [CW-1:0]   count;

    // The buffer itself is the slave; the fetch/decode environment is the master.
    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

endinterface

// File: rtl/fetch_buf_ram.sv
// Storage array for the prefetch buffer: one synchronous write, one async read port.
// Latency: write visible on the read port after the writing edge.
// Backpressure: none; the caller gates wr_en.
module fetch_buf_ram
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  entry_t                   wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output entry_t                   rd_data
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch FIFO feeding IF/ID; a flush discards every queued entry.
// Latency: 1 cycle push-to-head; 0 cycles when FETCH_BUF_BYPASS_EN is defined and empty.
// Backpressure: in_ready = not full from registered state only; out_ready stalls the head.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    entry_t        wr_entry;
    entry_t        head;

    assign empty        = (cnt == '0);
    // armed holds in_ready low until the first clock after reset release.
    assign bus.in_ready = armed && (cnt < FULL_CNT);
    assign bus.count    = cnt;

    always_comb begin
        bypass = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
        bypass = empty && bus.in_valid && bus.in_ready && bus.out_ready && !bus.flush;
`endif
    end

    assign push = bus.in_valid && bus.in_ready && !bus.flush && !bypass;
    assign pop  = !empty && bus.out_ready && !bus.flush;

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_pc    = '0;
        bus.out_instr = XLEN'(NOP_INSTR);
        if (bypass) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = bus.in_pc;
            bus.out_instr = bus.in_instr;
        end else if (!empty) begin
            bus.out_valid = !bus.flush;
            bus.out_pc    = head.pc;
            bus.out_instr = head.instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (bus.flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign wr_entry.pc    = bus.in_pc;
    assign wr_entry.instr = bus.in_instr;

    fetch_buf_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
Small instruction prefetch FIFO between the instruction-memory response path and the IF/ID pipeline register. It decouples fetch from decode stalls by queuing up to DEPTH {pc, instr} pairs. It presents them in order to the IF/ID register over a valid/ready handshake. A branch/jump redirect flushes all queued entries.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
XLEN, 32, width of pc and instr fields

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  imem response valid
in_ready  output  1  buffer can accept an entry this cycle
in_pc  input  XLEN  pc of incoming instruction
in_instr  input  XLEN  incoming instruction word
flush  input  1  redirect; discard all entries
out_valid  output  1  head entry valid to IF/ID register
out_ready  input  1  IF/ID register accepts; driven as ~StallD
out_pc  output  XLEN  head pc
out_instr  output  XLEN  head instruction
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (reset=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, in_ready=0. Storage contents are not reset.
- First clock after reset deasserts: in_ready=1.
- Push occurs when in_valid && in_ready. The entry is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Pop occurs when out_valid && out_ready. rd_ptr advances modulo DEPTH.
- in_ready = (count < DEPTH). It is a pure function of registered state, with no combinational path from out_ready. When full, no push is accepted, even in a popping cycle.
- out_valid = (count != 0) && !flush.
- out_pc/out_instr show the head entry.
- When empty, out_instr = NOP_INSTR (0x00000013) and out_pc = 0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap from DEPTH-1 to 0. Use pointers of $clog2(DEPTH) bits plus a separate count register; no extra wrap bit.
- Ordering is strict FIFO. Entries are never reordered or dropped except by flush.
- Flush is synchronous and takes priority over push and pop. On the next edge, count=0 and rd_ptr=wr_ptr=0. An entry presented with in_valid in the flush cycle is discarded. out_valid=0 during the flush cycle, so IF/ID cannot capture a stale entry.
- Flush while empty: no effect beyond clearing the pointers.
- Reset asserted mid-operation: all state is cleared immediately, regardless of the clock. Queued entries are lost.
- Latency, without the optional feature: an entry pushed at edge N is visible on out_* after edge N. It can be popped at edge N+1.

Optional Feature:
Macro: FETCH_BUF_BYPASS_EN
- Defined:
  - When count==0, in_valid=1, out_ready=1 and flush=0, the input passes combinationally to out_valid/out_pc/out_instr.
  - The entry is consumed in that same cycle and is not written; count stays 0.
  - in_ready is unchanged (still registered-only).
- Not defined: no bypass; minimum latency is one cycle as stated above.

Decomposition:
- Package fetch_pkg:
  - XLEN_DEFAULT = 32
  - NOP_INSTR = 32'h00000013
  - typedef fetch_entry_t, a packed struct {pc, instr}
- Sub-module fetch_buf_ram:
  - DEPTH x fetch_entry_t register array
  - one synchronous write port, one asynchronous read port
  - no reset
- fetch_buffer holds the pointers, count, handshake and flush logic.

Test Plan:
1. Reset, then push pc=0x0,0x4,0x8,0xC (instr 0x00100093, 0x00200113, 0x00300193, 0x00400213) with out_ready=0 -> count=4, in_ready=0. A fifth push (pc=0x10) is refused and count stays 4.
2. From full, out_ready=1 with in_valid=0 for 4 cycles -> out_pc sequence 0x0, 0x4, 0x8, 0xC, then out_valid=0, out_instr=0x00000013, count=0.
3. Simultaneous push/pop at count=2 for 6 cycles with incrementing pc -> count stays 2, outputs in order, pointers wrap past DEPTH-1 with no lost entry.
4. Three entries queued, assert flush with in_valid=1 (pc=0x40) -> out_valid=0 that cycle, count=0 next cycle, and the pc=0x40 entry never appears on out_pc.
5. Drive reset=0 asynchronously mid-cycle with count=3 -> count=0, out_valid=0, in_ready=0 immediately, before the next clock edge.
6. Empty buffer, in_valid=1 with pc=0x20, out_ready=1:
   - FETCH_BUF_BYPASS_EN defined -> out_valid=1 and out_pc=0x20 in the same cycle, count stays 0.
   - Undefined -> out_valid=1 one cycle later.
